// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART transmitter. Serialises one word per valid/ready handshake as
//            start bit, LSB-first data, optional parity bit and stop bit.
//            Build macro UART_TX_ODD_PARITY_EN selects odd parity (default even).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int CLOCKS_PER_BIT   = 5000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [INPUT_DATA_WIDTH-1:0] tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        serial_out,
    output logic                        tx_busy
);

    localparam int c_CNT_W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int c_IDX_W = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(INPUT_DATA_WIDTH - 1);

`ifdef UART_TX_ODD_PARITY_EN
    localparam logic c_PAR_INV = 1'b1;
`else
    localparam logic c_PAR_INV = 1'b0;
`endif

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_START  = 3'd1;
    localparam logic [2:0] c_S_DATA   = 3'd2;
    localparam logic [2:0] c_S_PARITY = 3'd3;
    localparam logic [2:0] c_S_STOP   = 3'd4;

    logic [2:0]                  r_state;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [c_IDX_W-1:0]          r_idx;
    logic [INPUT_DATA_WIDTH-1:0] r_shift;
    logic                        r_parity;
    logic                        r_serial;

    logic [2:0]                  w_state_nxt;
    logic [c_CNT_W-1:0]          w_cnt_nxt;
    logic [c_IDX_W-1:0]          w_idx_nxt;
    logic [INPUT_DATA_WIDTH-1:0] w_shift_nxt;
    logic                        w_parity_nxt;
    logic                        w_serial_nxt;
    logic                        w_tick;
    logic                        w_accept;

    assign w_tick     = (r_cnt == c_CNT_LAST);
    assign tx_ready   = (r_state == c_S_IDLE) || ((r_state == c_S_STOP) && w_tick);
    assign w_accept   = tx_valid && tx_ready;
    assign tx_busy    = (r_state != c_S_IDLE);
    assign serial_out = r_serial;

    // Every non-idle state leaves on its final baud tick, so the counter
    // only ever resets from c_CNT_LAST and never wraps on its own.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt + 1'b1;
        w_idx_nxt    = r_idx;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        case (r_state)
            c_S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_accept) begin
                    w_state_nxt  = c_S_START;
                    w_shift_nxt  = tx_data;
                    w_parity_nxt = (^tx_data) ^ c_PAR_INV;
                end
            end
            c_S_START: begin
                if (w_tick) begin
                    w_state_nxt = c_S_DATA;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            c_S_DATA: begin
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    w_idx_nxt   = r_idx + 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = (PARITY_ENABLED != 0) ? c_S_PARITY : c_S_STOP;
                        w_idx_nxt   = '0;
                    end
                end
            end
            c_S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = c_S_STOP;
                    w_cnt_nxt   = '0;
                end
            end
            c_S_STOP: begin
                if (w_tick) begin
                    w_cnt_nxt = '0;
                    if (tx_valid) begin
                        w_state_nxt  = c_S_START;
                        w_shift_nxt  = tx_data;
                        w_parity_nxt = (^tx_data) ^ c_PAR_INV;
                    end else begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Line level is registered from next-state values so it changes on the
    // same edge as the state, with no input-to-pin combinational path.
    always_comb begin
        w_serial_nxt = 1'b1;
        case (w_state_nxt)
            c_S_START:  w_serial_nxt = 1'b0;
            c_S_DATA:   w_serial_nxt = w_shift_nxt[0];
            c_S_PARITY: w_serial_nxt = w_parity_nxt;
            default:    w_serial_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_serial <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
            r_serial <= w_serial_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx (parity and no-parity instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int C   = 8;
    localparam int FL  = 11 * C;
    localparam int NFL = 10 * C;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, serial_out, tx_busy;
    logic [7:0] np_data = 8'h00;
    logic       np_valid = 1'b0;
    logic       np_ready, np_serial, np_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(.INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1), .CLOCKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .serial_out(serial_out), .tx_busy(tx_busy)
    );

    uart_tx #(.INPUT_DATA_WIDTH(8), .PARITY_ENABLED(0), .CLOCKS_PER_BIT(C)) dut_np (
        .clk(clk), .reset(reset), .tx_data(np_data), .tx_valid(np_valid),
        .tx_ready(np_ready), .serial_out(np_serial), .tx_busy(np_busy)
    );

    // Reference: expected line level k cycles after the accepting edge.
    function automatic logic exp_line(input logic [7:0] d, input int k, input bit par_en);
        int b;
        int ones;
        b    = k / C;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (par_en && b == 9) begin
`ifdef UART_TX_ODD_PARITY_EN
            return (ones % 2) == 0;
`else
            return (ones % 2) == 1;
`endif
        end
        return 1'b1;
    endfunction

    task automatic accept(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (serial_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held serial=%b ready=%b busy=%b required 1/1/0", serial_out, tx_ready, tx_busy);
        end
        reset = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            n_vec++;
            if (serial_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || np_serial !== 1'b1) begin
                n_err++;
                $display("FAIL idle_after_reset cyc=%0d serial=%b ready=%b busy=%b np=%b required 1/1/0/1",
                         k, serial_out, tx_ready, tx_busy, np_serial);
            end
        end
    endtask

    task automatic test_frame(input logic [7:0] d);
        accept(d);
        for (int k = 0; k < FL; k++) begin
            if (k == 3 * C) tx_data = ~d;
            n_vec++;
            if (serial_out !== exp_line(d, k, 1'b1) || tx_busy !== 1'b1 || tx_ready !== (k == FL - 1)) begin
                n_err++;
                $display("FAIL frame d=%h k=%0d serial=%b busy=%b ready=%b required serial=%b busy=1 ready=%b",
                         d, k, serial_out, tx_busy, tx_ready, exp_line(d, k, 1'b1), (k == FL - 1));
            end
            @(negedge clk);
        end
        n_vec++;
        if (serial_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL frame_end d=%h serial=%b ready=%b busy=%b required 1/1/0", d, serial_out, tx_ready, tx_busy);
        end
    endtask

    task automatic test_parity_bit();
        logic exp_p;
`ifdef UART_TX_ODD_PARITY_EN
        exp_p = 1'b0;
`else
        exp_p = 1'b1;
`endif
        accept(8'h01);
        for (int k = 0; k < FL; k++) begin
            if (k == 9 * C + C / 2) begin
                n_vec++;
                if (serial_out !== exp_p) begin
                    n_err++;
                    $display("FAIL parity_0x01 got=%b required=%b", serial_out, exp_p);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < FL; k++) begin
            if (k == 20) tx_data = 8'h00;
            if (k == 50) tx_data = 8'hFF;
            n_vec++;
            if (serial_out !== exp_line(8'h55, k, 1'b1) || tx_busy !== 1'b1 || tx_ready !== (k == FL - 1)) begin
                n_err++;
                $display("FAIL b2b_first k=%0d serial=%b busy=%b ready=%b required serial=%b",
                         k, serial_out, tx_busy, tx_ready, exp_line(8'h55, k, 1'b1));
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        for (int k = 0; k < FL; k++) begin
            n_vec++;
            if (serial_out !== exp_line(8'hFF, k, 1'b1) || tx_busy !== 1'b1 || tx_ready !== (k == FL - 1)) begin
                n_err++;
                $display("FAIL b2b_second k=%0d serial=%b busy=%b ready=%b required serial=%b",
                         k, serial_out, tx_busy, tx_ready, exp_line(8'hFF, k, 1'b1));
            end
            @(negedge clk);
        end
        n_vec++;
        if (tx_busy !== 1'b0 || serial_out !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_end busy=%b serial=%b required 0/1", tx_busy, serial_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        accept(8'h3C);
        for (int k = 0; k <= 4 * C + 3; k++) begin
            n_vec++;
            if (serial_out !== exp_line(8'h3C, k, 1'b1)) begin
                n_err++;
                $display("FAIL midreset_pre k=%0d serial=%b required=%b", k, serial_out, exp_line(8'h3C, k, 1'b1));
            end
            if (k != 4 * C + 3) @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_async serial=%b busy=%b ready=%b required 1/0/1", serial_out, tx_busy, tx_ready);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (serial_out !== 1'b1 || tx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_release serial=%b busy=%b required 1/0", serial_out, tx_busy);
        end
        test_frame(8'h3C);
    endtask

    task automatic test_no_parity();
        logic [9:0] rx;
        rx       = '0;
        np_data  = 8'h80;
        np_valid = 1'b1;
        @(negedge clk);
        np_valid = 1'b0;
        np_data  = 8'h00;
        for (int k = 0; k < NFL; k++) begin
            if (k % C == C / 2) rx[k / C] = np_serial;
            n_vec++;
            if (np_serial !== exp_line(8'h80, k, 1'b0) || np_busy !== 1'b1 || np_ready !== (k == NFL - 1)) begin
                n_err++;
                $display("FAIL noparity k=%0d serial=%b busy=%b ready=%b required serial=%b",
                         k, np_serial, np_busy, np_ready, exp_line(8'h80, k, 1'b0));
            end
            @(negedge clk);
        end
        n_vec++;
        if (np_busy !== 1'b0 || np_ready !== 1'b1 || np_serial !== 1'b1) begin
            n_err++;
            $display("FAIL noparity_end busy=%b ready=%b serial=%b required 0/1/1", np_busy, np_ready, np_serial);
        end
        n_vec++;
        if (rx[0] !== 1'b0 || rx[8:1] !== 8'h80 || rx[9] !== 1'b1) begin
            n_err++;
            $display("FAIL loopback_rx start=%b data=%h stop=%b required 0/80/1", rx[0], rx[8:1], rx[9]);
        end
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            test_frame(d);
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5);
        test_parity_bit();
        test_back_to_back();
        test_reset_mid_frame();
        test_no_parity();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

UART transmitter; the transmit-side counterpart of the Rx path (start-bit detector plus bit sampler). Accepts a parallel byte over a valid/ready handshake and serialises it onto `serial_out` as one start bit, INPUT_DATA_WIDTH data bits LSB-first, an optional parity bit and one stop bit, at CLOCKS_PER_BIT system clocks per bit. Sits between the host-side data source and the board TX pin, frame-compatible with the Rx path at identical parameters.

## Interface
- INPUT_DATA_WIDTH, 8: data bits per frame.
- PARITY_ENABLED, 1: 1 = insert parity bit after data; 0 = no parity bit.
- CLOCKS_PER_BIT, 5000: system clocks per UART bit (48 MHz / 9600 Bd); benches use 8.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  INPUT_DATA_WIDTH  byte to send; sampled only on accept.
- tx_valid  input  1  source has a byte.
- tx_ready  output  1  transmitter can accept; accept = tx_valid && tx_ready at posedge.
- serial_out  output  1  UART line, idle high.
- tx_busy  output  1  high whenever a frame is on the line (state != IDLE).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: serial_out=1, tx_ready=1, tx_busy=0. On accept: latch tx_data into a shift register, compute parity, go to START.
- START: serial_out=0 for CLOCKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: serial_out=shift[0]; after CLOCKS_PER_BIT cycles shift right, increment index; after bit INPUT_DATA_WIDTH-1 go to PARITY (PARITY_ENABLED=1) or STOP.
- PARITY: serial_out=parity bit for CLOCKS_PER_BIT cycles, then STOP. Default parity is even: XOR of latched data bits.
- STOP: serial_out=1 for CLOCKS_PER_BIT cycles. tx_ready=1 during the final cycle of STOP only; accept there goes straight to START (back-to-back frames, no idle gap); else to IDLE.
- Baud counter: width $clog2(CLOCKS_PER_BIT), counts 0..CLOCKS_PER_BIT-1, clears on every state transition and on accept; never wraps past CLOCKS_PER_BIT-1.
- Bit index: width $clog2(INPUT_DATA_WIDTH), used only in DATA.
- tx_data changes after accept do not affect the frame in progress; tx_valid while tx_ready=0 is ignored (not queued).
- serial_out is driven from a register; no combinational path from inputs to serial_out.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, serial_out=1, tx_ready=1, tx_busy=0, counters and shift register 0. Reset mid-frame abandons the frame immediately; the line returns high without waiting for a clock edge.
- Accept at posedge T: serial_out falls and tx_busy rises at T (visible after edge T); tx_ready falls at T.
- Frame length: (INPUT_DATA_WIDTH + 2 + PARITY_ENABLED) × CLOCKS_PER_BIT cycles from edge T until line/ready free; 11 × CLOCKS_PER_BIT at defaults.
- Each bit is held exactly CLOCKS_PER_BIT cycles; bit k of data starts at T + (1+k)·CLOCKS_PER_BIT.
- Back-to-back: next start bit begins exactly 11·CLOCKS_PER_BIT cycles after previous accept.

## Configuration
- UART_TX_ODD_PARITY_EN: defined → parity bit = ~(XOR of data bits) (odd parity). Undefined → even parity. No effect when PARITY_ENABLED=0.

## Test plan
- Reset held then released, tx_valid=0 for 200 cycles -> serial_out=1, tx_ready=1, tx_busy=0 throughout.
- CLOCKS_PER_BIT=8, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,0(even parity),1, each bit 8 cycles; tx_ready back high 88 cycles after accept.
- Send 0x01 with UART_TX_ODD_PARITY_EN defined -> parity bit 0; without macro -> parity bit 1.
- tx_valid held high with 0x55 then 0xFF -> second start bit exactly 88 cycles after first accept, no idle cycle; tx_data changed to 0x00 mid-frame does not alter the first frame.
- reset asserted during DATA bit 3 of 0x3C -> serial_out=1 immediately, tx_busy=0; after release, 0x3C resent as a complete correct frame.
- PARITY_ENABLED=0, send 0x80 -> 10-bit frame (80 cycles), stop bit directly after data bit 7; loop serial_out into Rx path and recover 0x80.
